i2c_cmd_fifo: RTL
=================

# i2c_cmd_fifo

Command/response buffering stage placed between the Wishbone register interface and the `i2c_master` bit engine in the icE1usb gateware. Software queues up to DEPTH I2C commands (START/STOP/WRITE/READ). A dispatcher FSM issues them to the core one at a time using its `stb`/`ready` handshake. WRITE ack bits and READ data bytes are collected into a response FIFO, so the CPU does not need to poll `ready` between bytes.

## Interface

Parameters:
- `DEPTH`, 16: entries in each FIFO; power of two, 2..256.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `wr_data`  in  11  command word: [10:9] cmd, [8] ack_in, [7:0] data
- `wr_ena`  in  1  push `wr_data` into the command FIFO
- `wr_full`  out  1  command FIFO full
- `rd_data`  out  9  response head: [8] ack, [7:0] data; forced 0 while `rd_empty`
- `rd_ena`  in  1  pop the response FIFO
- `rd_empty`  out  1  response FIFO empty
- `flush`  in  1  one-cycle pulse; empties both FIFOs
- `busy`  out  1  command FIFO non-empty, or FSM not in IDLE
- `core_cmd`  out  2  to `i2c_master.cmd`
- `core_ack_in`  out  1  to `i2c_master.ack_in`
- `core_data_in`  out  8  to `i2c_master.data_in`
- `core_stb`  out  1  to `i2c_master.stb`
- `core_ready`  in  1  from `i2c_master.ready`
- `core_ack_out`  in  1  from `i2c_master.ack_out`
- `core_data_out`  in  8  from `i2c_master.data_out`

## Operation

- Command encoding: 00 START, 01 STOP, 10 WRITE, 11 READ.
- Only WRITE and READ produce a response entry:
  - WRITE: {`core_ack_out`, `core_data_out`}; software uses bit 8.
  - READ: {`core_ack_out`, `core_data_out`}; software uses [7:0].
- Command FIFO:
  - `wr_ena` while `wr_full` is ignored. `wr_full` is evaluated before any same-cycle dispatcher pop.
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full when the MSBs differ and the rest are equal.
- Response FIFO:
  - First-word-fall-through.
  - `rd_ena` while `rd_empty` is ignored.
  - Push and pop in the same cycle are both honoured.
- Dispatcher FSM:
  - IDLE:
    - If the command FIFO is non-empty and `core_ready`=1, pop the head into the issue register (`core_cmd`/`core_ack_in`/`core_data_in`) and go to ISSUE.
    - If the head is WRITE/READ and the response FIFO is full, stay in IDLE (no pop).
    - START/STOP are never blocked by a full response FIFO.
  - ISSUE: `core_stb`=1 for exactly this cycle; go to BUSY.
  - BUSY:
    - `core_ready` is guaranteed low in the first BUSY cycle.
    - On the first cycle with `core_ready`=1: if the issued cmd[1]=1, push the response; go to IDLE.
- The issue register holds its value until the next pop; the core may sample it at any time.
- `flush`:
  - Clears both FIFO pointers.
  - If the FSM is in ISSUE or BUSY, the command completes on the bus, but its response is discarded (a drop flag is set and cleared on return to IDLE).
  - A `wr_ena` in the same cycle as `flush` is dropped.
- Reset mid-transfer: the FSM returns to IDLE immediately. Core reset is shared, so the bus is abandoned.
- Reset values:
  - `wr_full`=0, `rd_empty`=1, `rd_data`=0, `busy`=0.
  - `core_stb`=0, `core_cmd`=00, `core_ack_in`=0, `core_data_in`=0.
  - FSM in IDLE, both FIFOs empty, drop flag=0.

## Timing

- `wr_ena` at cycle t: command FIFO non-empty at t+1, pop in IDLE at t+1, `core_stb` high at t+2.
- Response push at cycle u (BUSY with `core_ready`=1): `rd_empty`=0 and `rd_data` valid at u+1.
- Back-to-back commands: one IDLE cycle between the core's `ready` return and the next ISSUE, so minimum spacing between `core_stb` pulses is (core op time)+2 cycles.
- `rd_ena` at t: the next entry (or `rd_empty`=1) is visible at t+1.
- `busy` is registered and reflects the state one cycle after its cause.

## Test plan

- Queue START, WRITE 0xA0 (core returns ack_out=0), READ with ack_in=1 (core data_out=0x5C), STOP. Required:
  - four `core_stb` pulses in order;
  - response FIFO holds exactly {0,xx} then {x,0x5C};
  - `busy` falls after STOP completes.
- Fill the command FIFO with DEPTH writes while `core_ready` is held low: `wr_full`=1 after the DEPTH-th write; a DEPTH+1-th write is ignored; exactly DEPTH commands are later issued.
- Queue DEPTH+2 WRITEs and never read responses: dispatcher stalls in IDLE after DEPTH responses, with `core_stb` silent. One `rd_ena` lets exactly one more command issue.
- Queue START then WRITE while the response FIFO is full: START still issues, WRITE waits.
- `flush` while a READ is in BUSY: the bus read completes; `rd_empty` stays 1; `busy`=0 after return to IDLE; the FIFOs accept new commands.
- Assert `rst` in BUSY with 3 commands queued: next cycle `core_stb`=0, `busy`=0, `rd_empty`=1, `wr_full`=0, and no further `core_stb` pulses.

Source files
------------

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo
// Command/response buffering between a register interface and an I2C bit
// engine. Commands are queued in a command FIFO and dispatched one at a time
// to the core via stb/ready. WRITE/READ results are collected in a
// first-word-fall-through response FIFO.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wr_data/wr_ena        command push ([10:9] cmd, [8] ack_in, [7:0] data)
//   wr_full               command FIFO full
//   rd_data/rd_ena        response head ([8] ack, [7:0] data) and pop
//   rd_empty              response FIFO empty
//   flush                 empties both FIFOs, discards an in-flight response
//   busy                  commands pending or dispatcher active (registered)
//   core_*                issue register and handshake towards the bit engine
module i2c_cmd_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] wr_data,
    input  logic        wr_ena,
    output logic        wr_full,
    output logic [8:0]  rd_data,
    input  logic        rd_ena,
    output logic        rd_empty,
    input  logic        flush,
    output logic        busy,
    output logic [1:0]  core_cmd,
    output logic        core_ack_in,
    output logic [7:0]  core_data_in,
    output logic        core_stb,
    input  logic        core_ready,
    input  logic        core_ack_out,
    input  logic [7:0]  core_data_out
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    logic [10:0] cmd_mem [DEPTH];
    logic [8:0]  rsp_mem [DEPTH];

    logic [AW:0] cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
    logic [AW:0] rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
    state_t      state_q, state_d;
    logic [1:0]  issue_cmd_q, issue_cmd_d;
    logic        issue_ack_q, issue_ack_d;
    logic [7:0]  issue_data_q, issue_data_d;
    logic        stb_q, stb_d;
    logic        busy_q, busy_d;
    logic        drop_q, drop_d;

    logic        cmd_empty_s, cmd_full_s, rsp_empty_s, rsp_full_s;
    logic        cmd_push_s, cmd_pop_s, rsp_push_s, rsp_pop_s;
    logic [10:0] cmd_head_s;

    // Full when the wrap bits differ and the index bits match.
    function automatic logic ptr_full(input logic [AW:0] wp, input logic [AW:0] rp);
        return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    endfunction

    // FIFO status, push/pop qualification and pointer next-state.
    always_comb begin
        cmd_empty_s = (cmd_wptr_q == cmd_rptr_q);
        cmd_full_s  = ptr_full(cmd_wptr_q, cmd_rptr_q);
        rsp_empty_s = (rsp_wptr_q == rsp_rptr_q);
        rsp_full_s  = ptr_full(rsp_wptr_q, rsp_rptr_q);
        cmd_head_s  = cmd_mem[cmd_rptr_q[AW-1:0]];
        // A write coinciding with flush is dropped along with the old contents.
        cmd_push_s  = wr_ena && !cmd_full_s && !flush;
        rsp_pop_s   = rd_ena && !rsp_empty_s;
        if (flush) begin
            cmd_wptr_d = '0;
            cmd_rptr_d = '0;
            rsp_wptr_d = '0;
            rsp_rptr_d = '0;
        end else begin
            cmd_wptr_d = cmd_wptr_q + (AW+1)'(cmd_push_s);
            cmd_rptr_d = cmd_rptr_q + (AW+1)'(cmd_pop_s);
            rsp_wptr_d = rsp_wptr_q + (AW+1)'(rsp_push_s);
            rsp_rptr_d = rsp_rptr_q + (AW+1)'(rsp_pop_s);
        end
    end

    // Dispatcher next-state, issue register and response push.
    always_comb begin
        state_d      = state_q;
        issue_cmd_d  = issue_cmd_q;
        issue_ack_d  = issue_ack_q;
        issue_data_d = issue_data_q;
        cmd_pop_s    = 1'b0;
        rsp_push_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // WRITE/READ (cmd[1]=1) need a free response slot; START/STOP never wait.
                if (!cmd_empty_s && core_ready && !flush &&
                    !(cmd_head_s[10] && rsp_full_s)) begin
                    cmd_pop_s    = 1'b1;
                    issue_cmd_d  = cmd_head_s[10:9];
                    issue_ack_d  = cmd_head_s[8];
                    issue_data_d = cmd_head_s[7:0];
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (core_ready) begin
                    rsp_push_s = issue_cmd_q[1] && !drop_q && !flush && !rsp_full_s;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered status/strobe; drop survives until the dispatcher returns to IDLE.
    always_comb begin
        drop_d = (state_d != ST_IDLE) && (drop_q || flush);
        stb_d  = (state_d == ST_ISSUE);
        busy_d = (cmd_wptr_d != cmd_rptr_d) || (state_d != ST_IDLE);
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wptr_q   <= '0;
            cmd_rptr_q   <= '0;
            rsp_wptr_q   <= '0;
            rsp_rptr_q   <= '0;
            state_q      <= ST_IDLE;
            issue_cmd_q  <= 2'b00;
            issue_ack_q  <= 1'b0;
            issue_data_q <= 8'h00;
            stb_q        <= 1'b0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            cmd_wptr_q   <= cmd_wptr_d;
            cmd_rptr_q   <= cmd_rptr_d;
            rsp_wptr_q   <= rsp_wptr_d;
            rsp_rptr_q   <= rsp_rptr_d;
            state_q      <= state_d;
            issue_cmd_q  <= issue_cmd_d;
            issue_ack_q  <= issue_ack_d;
            issue_data_q <= issue_data_d;
            stb_q        <= stb_d;
            busy_q       <= busy_d;
            drop_q       <= drop_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (cmd_push_s) begin
            cmd_mem[cmd_wptr_q[AW-1:0]] <= wr_data;
        end
        if (rsp_push_s) begin
            rsp_mem[rsp_wptr_q[AW-1:0]] <= {core_ack_out, core_data_out};
        end
    end

    assign wr_full      = cmd_full_s;
    assign rd_empty     = rsp_empty_s;
    assign rd_data      = rsp_empty_s ? 9'd0 : rsp_mem[rsp_rptr_q[AW-1:0]];
    assign busy         = busy_q;
    assign core_stb     = stb_q;
    assign core_cmd     = issue_cmd_q;
    assign core_ack_in  = issue_ack_q;
    assign core_data_in = issue_data_q;

endmodule
